// File: rtl/mem_arbiter.sv
// Arbiter that shares a single-port RAM between the CPU and the debug/loader port.
// It latches the granted request, sequences one RAM access and returns a one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dev_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam bit       FIXED_PRIO = (ARB_MODE == 1);
  localparam bit [2:0] WAIT_INIT  = 3'(RD_LAT - 1);

  state_t   state;
  owner_t   owner;
  owner_t   last_owner;
  logic     lat_we;
  logic [2:0] wait_cnt;

  logic cpu_eff;
  logic grant_cpu;
  logic grant_dbg;

  // CPU wins a tie under fixed priority, or when the loader was served last.
  always_comb begin
    cpu_eff   = cpu_req & ~dbg_lock;
    grant_cpu = cpu_eff & (~dbg_req | FIXED_PRIO | (last_owner == OWN_DBG));
    grant_dbg = dbg_req & ~grant_cpu;
  end

  assign dev_state = state;

  // NOTE: every register here is assigned with <= so all of them update together
  // from values sampled at the same edge; blocking = would make order matter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_DBG;
      lat_we     <= 1'b0;
      wait_cnt   <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu || grant_dbg) begin
            owner     <= grant_cpu ? OWN_CPU : OWN_DBG;
            lat_we    <= grant_cpu ? cpu_we : dbg_we;
            mem_en    <= 1'b1;
            mem_we    <= grant_cpu ? cpu_we : dbg_we;
            mem_addr  <= grant_cpu ? cpu_addr : dbg_addr;
            mem_wdata <= grant_cpu ? cpu_wdata : dbg_wdata;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (lat_we) begin
            cpu_ack <= (owner == OWN_CPU);
            dbg_ack <= (owner == OWN_DBG);
            state   <= DONE;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
            else                  dbg_rdata <= mem_rdata;
            cpu_ack <= (owner == OWN_CPU);
            dbg_ack <= (owner == OWN_DBG);
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: begin
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance A (round-robin, RD_LAT=1) and
// instance B (fixed priority, RD_LAT=3) share one stimulus bus selected by sel.
module tb_mem_arbiter;

  typedef struct {
    bit         is_cpu;
    bit         is_read;
    logic [7:0] rdata;
    int         ack_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic [7:0] mem_rdata;

  logic       a_cpu_ack, a_dbg_ack, a_mem_en, a_mem_we, a_busy;
  logic [7:0] a_cpu_rdata, a_dbg_rdata, a_mem_addr, a_mem_wdata;
  logic [1:0] a_dev_state;
  logic       b_cpu_ack, b_dbg_ack, b_mem_en, b_mem_we, b_busy;
  logic [7:0] b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata;
  logic [1:0] b_dev_state;

  logic       cpu_ack, dbg_ack, mem_en, mem_we, busy;
  logic [7:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic [1:0] dev_state;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   en_cnt = 0;
  int   cyc = 0;

  logic [7:0] ram [256];
  logic [7:0] pipe [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req & ~sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .dbg_req(dbg_req & ~sel), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(a_dbg_ack), .dbg_rdata(a_dbg_rdata), .dbg_lock(dbg_lock),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata), .busy(a_busy), .dev_state(a_dev_state)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req & sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .dbg_req(dbg_req & sel), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata), .dbg_lock(dbg_lock),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata), .busy(b_busy), .dev_state(b_dev_state)
  );

  assign cpu_ack   = sel ? b_cpu_ack   : a_cpu_ack;
  assign dbg_ack   = sel ? b_dbg_ack   : a_dbg_ack;
  assign cpu_rdata = sel ? b_cpu_rdata : a_cpu_rdata;
  assign dbg_rdata = sel ? b_dbg_rdata : a_dbg_rdata;
  assign mem_en    = sel ? b_mem_en    : a_mem_en;
  assign mem_we    = sel ? b_mem_we    : a_mem_we;
  assign mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign busy      = sel ? b_busy      : a_busy;
  assign dev_state = sel ? b_dev_state : a_dev_state;

  // RAM model: read data appears 1 (A) or 3 (B) cycles after the enable cycle.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 8'h00;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign mem_rdata = sel ? pipe[2] : pipe[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every ack and checks bus invariants each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_en) en_cnt++;
      else check("mem_idle_zero", {15'b0, mem_we, mem_addr, mem_wdata}, 0);
      check("ack_overlap", {31'b0, cpu_ack & dbg_ack}, 0);
      if (cpu_ack || dbg_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {30'b0, cpu_ack, dbg_ack}, 0);
        end else begin
          e = sb.pop_front();
          check("ack_owner_is_cpu", {31'b0, cpu_ack}, {31'b0, e.is_cpu});
          check("ack_cycle", cyc, e.ack_cyc);
          if (e.is_read) check("ack_rdata", e.is_cpu ? cpu_rdata : dbg_rdata, e.rdata);
        end
      end
    end
  end

  // Called on a negedge with the DUT idle; returns on the negedge of the next IDLE cycle.
  task automatic access(input bit is_cpu, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd, input bit lock_in_wait);
    exp_t e;
    bit   got;
    int   rl;
    rl        = sel ? 3 : 1;
    e.is_cpu  = is_cpu;
    e.is_read = !we;
    e.rdata   = exp_rd;
    e.ack_cyc = cyc + (we ? 2 : rl + 2);
    sb.push_back(e);
    if (is_cpu) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (lock_in_wait && dev_state == 2'd2) dbg_lock = 1'b1;
      if (is_cpu ? cpu_ack : dbg_ack) got = 1'b1;
    end
    check("ack_timeout", {31'b0, got}, 1);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    if (lock_in_wait) dbg_lock = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic new_sel);
    rst = 1'b0;
    sel = new_sel;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  en0;
    int  n0;
    int  cnt;
    bit  got;

    repeat (2) @(negedge clk);
    check("rst_dev_state", {30'b0, dev_state}, 0);
    check("rst_busy",      {31'b0, busy}, 0);
    check("rst_acks",      {30'b0, cpu_ack, dbg_ack}, 0);
    check("rst_mem_en",    {31'b0, mem_en}, 0);
    check("rst_cpu_rdata", {24'b0, cpu_rdata}, 0);
    check("rst_dbg_rdata", {24'b0, dbg_rdata}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Loader write then CPU read of the same location.
    en0 = en_cnt;
    access(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
    access(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    check("t1_en_pulses", en_cnt - en0, 2);
    check("t1_cpu_rdata_hold", {24'b0, cpu_rdata}, 32'hA5);
    access(1'b0, 1'b1, 8'h11, 8'h5A, 8'h00, 1'b0);

    // Round-robin with both requesters held: CPU first after reset, then alternate.
    do_reset(1'b0);
    n0 = cyc;
    for (int k = 0; k < 6; k++) sb.push_back('{(k % 2) == 0, 1'b0, 8'h00, n0 + 2 + 3 * k});
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h11;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h41; dbg_wdata = 8'h22;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 6; i++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) cnt++;
    end
    check("t2_ack_count", cnt, 6);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);

    // Locked CPU request is never granted.
    dbg_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    repeat (8) @(negedge clk);
    check("t4_lock_busy", {31'b0, busy}, 0);
    check("t4_lock_state", {30'b0, dev_state}, 0);
    cpu_req = 1'b0;
    dbg_lock = 1'b0;
    @(negedge clk);
    // Lock rising while a granted CPU read sits in WAIT does not abort it.
    access(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1);

    // Reset during a loader read in WAIT aborts it cleanly.
    access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h11;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dev_state == 2'd2) got = 1'b1;
    end
    check("t5_reached_wait", {31'b0, got}, 1);
    rst = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    check("t5_no_ack",    {31'b0, dbg_ack}, 0);
    check("t5_mem_en",    {31'b0, mem_en}, 0);
    check("t5_busy",      {31'b0, busy}, 0);
    check("t5_state",     {30'b0, dev_state}, 0);
    check("t5_dbg_rdata", {24'b0, dbg_rdata}, 0);
    check("t5_cpu_rdata", {24'b0, cpu_rdata}, 0);
    rst = 1'b1;
    @(negedge clk);
    access(1'b0, 1'b0, 8'h11, 8'h00, 8'h5A, 1'b0);

    // Instance B: fixed priority, RD_LAT=3.
    do_reset(1'b1);
    access(1'b0, 1'b1, 8'h20, 8'h3C, 8'h00, 1'b0);
    access(1'b0, 1'b1, 8'h30, 8'h77, 8'h00, 1'b0);
    n0 = cyc;
    for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 1'b0, 8'h00, n0 + 2 + 3 * k});
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h33;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h51; dbg_wdata = 8'h44;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 4; i++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) cnt++;
    end
    check("t3_ack_count", cnt, 4);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);

    access(1'b0, 1'b0, 8'h30, 8'h00, 8'h77, 1'b0);
    access(1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 1'b0);
    check("t6_dbg_rdata_kept", {24'b0, dbg_rdata}, 32'h77);
    check("t6_cpu_rdata", {24'b0, cpu_rdata}, 32'h3C);

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
